// File: rtl/pc_sequencer.sv
// Fetch-stage program counter with prioritised redirects, stall support and a
// small circular return-address stack for call/return prediction.
module pc_sequencer #(
    parameter int unsigned        ADDR_W     = 32,
    parameter int unsigned        INC        = 4,
    parameter logic [ADDR_W-1:0]  RESET_PC   = '0,
    parameter logic [ADDR_W-1:0]  EXC_VECTOR = ADDR_W'(32'h8000_0180),
    parameter int unsigned        RAS_DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              exception,
    input  logic              jump_reg,
    input  logic [ADDR_W-1:0] jump_reg_target,
    input  logic              jump,
    input  logic [ADDR_W-1:0] jump_target,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic              link,
    input  logic              ret,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_plus_inc,
    output logic [ADDR_W-1:0] ras_top,
    output logic              ras_valid,
    output logic              ras_overflow,
    output logic              misaligned
);

    localparam int unsigned      PTR_W    = $clog2(RAS_DEPTH);
    localparam int unsigned      CNT_W    = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RAS_DEPTH);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] ras_q [RAS_DEPTH];
    logic [PTR_W-1:0]  top_q, top_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ovf_q, ovf_d;
    logic              push, pop;

    assign pc_plus_inc = pc_q + ADDR_W'(INC);

    // Next-PC select; exception bypasses stall and never touches the RAS.
    always_comb begin
        pc_d = pc_q;
        push = 1'b0;
        pop  = 1'b0;
        if (exception) begin
            pc_d = EXC_VECTOR;
        end else if (!stall) begin
            if (jump_reg) begin
                pc_d = jump_reg_target;
                pop  = ret;
            end else if (jump) begin
                pc_d = jump_target;
                push = link;
            end else if (branch_taken) begin
                pc_d = branch_target;
            end else begin
                pc_d = pc_plus_inc;
            end
        end
    end

    // Circular stack: a push when full overwrites the oldest entry.
    always_comb begin
        top_d = top_q;
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (push) begin
            top_d = top_q + PTR_W'(1);
            if (cnt_q == CNT_FULL) begin
                ovf_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else if (pop && (cnt_q != '0)) begin
            top_d = top_q - PTR_W'(1);
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q  <= RESET_PC;
            top_q <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            top_q <= top_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RAS_DEPTH; i++) begin
                ras_q[i] <= '0;
            end
        end else if (push) begin
            ras_q[top_d] <= pc_plus_inc;
        end
    end

    assign pc           = pc_q;
    assign ras_valid    = (cnt_q != '0);
    assign ras_top      = ras_valid ? ras_q[top_q] : '0;
    assign ras_overflow = ovf_q;

    generate
        if (INC > 1) begin : g_align
            assign misaligned = |pc_q[$clog2(INC)-1:0];
        end else begin : g_no_align
            assign misaligned = 1'b0;
        end
    endgenerate

endmodule
